// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    FLUSH,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam int HDR_BYTES     = 2;
  localparam int TRAILER_BYTES = 4;
  localparam int LANE_W        = 8;
  localparam int WORD_W        = 4 * LANE_W;

  // Byte address of an instruction word index.
  function automatic logic [31:0] byte_addr(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words and pulses word_valid
// for one cycle after each fourth byte.
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              take,
  input  logic [LANE_W-1:0] data,
  output logic              last_lane,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]                 lane_q;
  logic [WORD_W-LANE_W-1:0]   acc_q;

  assign last_lane = (lane_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q     <= '0;
      acc_q      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= take && last_lane;
      if (clear) begin
        lane_q <= '0;
      end else if (take) begin
        lane_q <= lane_q + 2'd1;
        // Byte lane n lands at [8*n +: 8]; lane 3 completes the word.
        case (lane_q)
          2'd0:    acc_q[0*LANE_W +: LANE_W] <= data;
          2'd1:    acc_q[1*LANE_W +: LANE_W] <= data;
          2'd2:    acc_q[2*LANE_W +: LANE_W] <= data;
          default: word <= {data, acc_q};
        endcase
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: streams a counted little-endian program image into instruction
// memory and holds the core in reset until done. Optional trailer checksum: INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [LANE_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wd,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   count_lo_q;
  logic [AW:0]         count_q;
  logic [AW-1:0]       idx_q;
  logic [2*LANE_W-1:0] hdr_count;
  logic                hdr_too_big;
  logic                hdr_zero;
  logic                start_ok;
  logic                data_take;
  logic                last_lane;
  logic                last_word;
  logic                word_done;

  assign hdr_count   = {s_data, count_lo_q};
  assign hdr_too_big = hdr_count > 16'(DEPTH);
  assign hdr_zero    = (hdr_count == '0);
  assign start_ok    = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign data_take   = s_valid && (state_q == DATA);
  assign word_done   = data_take && last_lane;
  assign last_word   = ({1'b0, idx_q} == (count_q - {{AW{1'b0}}, 1'b1}));

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = CSUM;

  logic [31:0]              sum_q;
  logic [WORD_W-LANE_W-1:0] trail_q;
  logic [1:0]               tlane_q;
  logic                     trail_last;
  logic                     trail_match;

  assign trail_last  = (tlane_q == 2'(TRAILER_BYTES - 1));
  assign trail_match = ({s_data, trail_q} == sum_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q   <= '0;
      trail_q <= '0;
      tlane_q <= '0;
    end else if (start_ok) begin
      sum_q   <= '0;
      tlane_q <= '0;
    end else begin
      if (mem_we) sum_q <= sum_q + mem_wd;
      if (s_valid && state_q == CSUM) begin
        trail_q <= {s_data, trail_q[WORD_W-LANE_W-1:LANE_W]};
        tlane_q <= tlane_q + 2'd1;
      end
    end
  end
`else
  localparam state_e AFTER_DATA = DONE;
`endif

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .take       (data_take),
    .data       (s_data),
    .last_lane  (last_lane),
    .word       (mem_wd),
    .word_valid (mem_we)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_lo_q <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      mem_addr   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) idx_q <= '0;
      if (s_valid && state_q == HDR0) count_lo_q <= s_data;
      if (s_valid && state_q == HDR1) count_q <= hdr_count[AW:0];
      if (word_done) begin
        mem_addr <= byte_addr(32'(idx_q));
        idx_q    <= idx_q + AW'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    core_rst_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = HDR0;
      end
      HDR0: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) state_d = HDR1;
      end
      HDR1: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          if (hdr_too_big)   state_d = ERR;
          else if (hdr_zero) state_d = AFTER_DATA;
          else               state_d = DATA;
        end
      end
      DATA: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid && last_lane && last_word) state_d = FLUSH;
      end
      FLUSH: begin
        busy    = 1'b1;
        state_d = AFTER_DATA;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      CSUM: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid && trail_last) state_d = trail_match ? DONE : ERR;
      end
`endif
      DONE: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
        if (start) state_d = HDR0;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_d = HDR0;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader; follows the
// INSTR_LOADER_CHECKSUM_EN setting of the build.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int base;

  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cnt = 0;

  instr_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_wd;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    if (gap) begin
      s_valid = 1'b0;
      tick();
    end
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("s_ready_wait", {31'd0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  // Image A: N=2, words 0x00000013 and 0x00100093 (+ trailer 0x001000A6).
  task automatic send_image_a(input bit gap, input logic [7:0] trail0);
    logic [7:0] img [0:9];
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 10; i++) send_byte(img[i], gap);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(trail0, gap);
    send_byte(8'h00, gap);
    send_byte(8'h10, gap);
    send_byte(8'h00, gap);
`else
    if (trail0 == 8'hff) send_byte(trail0, gap);
`endif
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("done_wait", {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"},    {31'd0, s_ready},    32'd0);
    check({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_err"},        {31'd0, err},        32'd0);
    check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    check({tag, "_mem_addr"},   mem_addr,            32'd0);
    check({tag, "_mem_wd"},     mem_wd,              32'd0);
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    #3;
    check_reset_values("por");
    #20 rst = 1'b1;
    tick();

    // Image A back-to-back, with inline write timing checks.
    pulse_start();
    check("a_busy", {31'd0, busy}, 32'd1);
    check("a_ready", {31'd0, s_ready}, 32'd1);
    check("a_core_held", {31'd0, core_rst_n}, 32'd0);
    base = wr_cnt;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("a_w0_we", {31'd0, mem_we}, 32'd1);
    check("a_w0_addr", mem_addr, 32'h0000_0000);
    check("a_w0_data", mem_wd, 32'h0000_0013);
    send_byte(8'h93, 0);
    check("a_we_pulse", {31'd0, mem_we}, 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    check("a_flush_we", {31'd0, mem_we}, 32'd1);
    check("a_flush_addr", mem_addr, 32'h0000_0004);
    check("a_flush_data", mem_wd, 32'h0010_0093);
    check("a_flush_ready", {31'd0, s_ready}, 32'd0);
    check("a_flush_busy", {31'd0, busy}, 32'd1);
    check("a_flush_done", {31'd0, done}, 32'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'ha6, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
`else
    tick();
`endif
    check("a_done", {31'd0, done}, 32'd1);
    check("a_core_run", {31'd0, core_rst_n}, 32'd1);
    check("a_idle_busy", {31'd0, busy}, 32'd0);
    check("a_err", {31'd0, err}, 32'd0);
    check("a_wr_count", 32'(wr_cnt - base), 32'd2);

    // Restart from DONE, then image A with s_valid toggling.
    pulse_start();
    check("b_core_held", {31'd0, core_rst_n}, 32'd0);
    check("b_busy", {31'd0, busy}, 32'd1);
    base = wr_cnt;
    send_image_a(1, 8'ha6);
    wait_done();
    check("b_wr_count", 32'(wr_cnt - base), 32'd2);
    check("b_w0_addr", wr_addr[base], 32'h0000_0000);
    check("b_w0_data", wr_data[base], 32'h0000_0013);
    check("b_w1_addr", wr_addr[base+1], 32'h0000_0004);
    check("b_w1_data", wr_data[base+1], 32'h0010_0093);

    // Oversized header N=1025.
    pulse_start();
    base = wr_cnt;
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check("c_err", {31'd0, err}, 32'd1);
    check("c_core_held", {31'd0, core_rst_n}, 32'd0);
    check("c_busy", {31'd0, busy}, 32'd0);
    check("c_ready", {31'd0, s_ready}, 32'd0);
    tick();
    check("c_no_write", 32'(wr_cnt - base), 32'd0);
    pulse_start();
    check("c_restart_err", {31'd0, err}, 32'd0);
    send_image_a(0, 8'ha6);
    wait_done();
    check("c_wr_count", 32'(wr_cnt - base), 32'd2);

    // N=1024 is accepted; reset mid word 1.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    check("d_max_err", {31'd0, err}, 32'd0);
    check("d_max_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    check("d_w0_data", mem_wd, 32'h0403_0201);
    send_byte(8'h05, 0);
    send_byte(8'h06, 0);
    #2 rst = 1'b0;
    #1;
    check_reset_values("midrst");
    #3 rst = 1'b1;
    tick();
    pulse_start();
    base = wr_cnt;
    send_image_a(0, 8'ha6);
    wait_done();
    check("d_reload_addr", wr_addr[base], 32'h0000_0000);
    check("d_reload_data", wr_data[base], 32'h0000_0013);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Bad trailer.
    pulse_start();
    send_image_a(0, 8'ha7);
    check("e_err", {31'd0, err}, 32'd1);
    check("e_core_held", {31'd0, core_rst_n}, 32'd0);
    check("e_done", {31'd0, done}, 32'd0);
`endif

    // N=0 image.
    pulse_start();
    base = wr_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
`endif
    check("f_done", {31'd0, done}, 32'd1);
    check("f_core_run", {31'd0, core_rst_n}, 32'd1);
    tick();
    check("f_no_write", 32'(wr_cnt - base), 32'd0);

    // start in DONE with a coincident byte: byte must wait for HDR0.
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h01;
    check("g_ready_in_done", {31'd0, s_ready}, 32'd0);
    tick();
    start = 1'b0;
    check("g_core_held", {31'd0, core_rst_n}, 32'd0);
    check("g_busy", {31'd0, busy}, 32'd1);
    base = wr_cnt;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hef, 0);
    send_byte(8'hbe, 0);
    send_byte(8'had, 0);
    send_byte(8'hde, 0);
    check("g_we", {31'd0, mem_we}, 32'd1);
    check("g_addr", mem_addr, 32'h0000_0000);
    check("g_data", mem_wd, 32'hdead_beef);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'hef, 0);
    send_byte(8'hbe, 0);
    send_byte(8'had, 0);
    send_byte(8'hde, 0);
`endif
    wait_done();
    check("g_wr_count", 32'(wr_cnt - base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time loader that writes a program image into the single-cycle core's instruction memory before the core runs. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the instruction memory write port. It holds the core in reset until the full image has been written. It is the write-side counterpart of the core's instruction fetch path.

## Interface
- DEPTH, 1024: instruction memory size in words; maximum accepted word count.
- AW, 10: word-index width, clog2(DEPTH).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  loader accepts a byte; a byte transfers when s_valid and s_ready are both high on a clock edge.
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  out  32  byte address of the write: word index << 2.
- mem_wd  out  32  write data word.
- core_rst_n  out  1  active-low reset to the core; low during load.
- busy  out  1  load in progress.
- done  out  1  image loaded successfully.
- err  out  1  load aborted.

## Operation
- Stream format:
  - 2-byte word count N, little-endian.
  - N words, 4 bytes each, little-endian.
  - With INSTR_LOADER_CHECKSUM_EN only: a 4-byte trailer.
- FSM states: IDLE, HDR0, HDR1, DATA, FLUSH, CSUM, DONE, ERR.
- IDLE:
  - On start, go to HDR0.
- HDR0 / HDR1:
  - Capture the low and high count bytes.
  - After HDR1: if N > DEPTH, go to ERR.
  - If N == 0, go to DONE, or to CSUM when checksum is enabled.
  - Otherwise go to DATA.
- DATA:
  - A 2-bit lane counter places each byte at [8*lane +: 8].
  - On the lane-3 transfer, the word is registered and the word index increments.
  - After word N-1, go to FLUSH.
- FLUSH:
  - One cycle; no byte is accepted.
  - The final write completes here.
  - Then go to DONE, or to CSUM when checksum is enabled.
- DONE: done=1 and core_rst_n=1. On start, go to HDR0.
- ERR: err=1 and core_rst_n=0. On start, go to HDR0. Reset also leaves ERR.
- s_ready = 1 in HDR0, HDR1, DATA and CSUM; 0 elsewhere. It is a decode of registered state and is independent of s_valid.
- busy = 1 in all states except IDLE, DONE and ERR.
- Word index wraps only by restart: a new load restarts the index at 0.
- Reset values:
  - state = IDLE.
  - s_ready, mem_we, busy, done, err = 0.
  - mem_addr, mem_wd = 0.
  - core_rst_n = 0: the core is held after power-up until the first successful load.
- Reset mid-load: everything returns to the reset values immediately (asynchronous). A partially written image is left in memory and is not cleared.
- Restart from DONE: core_rst_n goes low in the same cycle that busy goes high.

## Timing
- Throughput: one byte per cycle; one word per 4 cycles.
- If the lane-3 transfer occurs at edge k, mem_we, mem_addr and mem_wd are valid in cycle k+1 for exactly one cycle.
- Final word handshake at edge k:
  - FLUSH occupies cycle k+1 and carries the final write.
  - done and core_rst_n go high in cycle k+2 when checksum is disabled.
- Stalls: when s_valid is low, nothing advances. Bytes are never dropped or duplicated.
- start coincident with an s_valid byte in IDLE or DONE: the byte is not consumed, because s_ready is still 0.

## Configuration
- INSTR_LOADER_CHECKSUM_EN defined:
  - Accumulate a 32-bit sum, mod 2^32, of all data words.
  - After the data, read the 4-byte little-endian trailer in CSUM.
  - If the trailer equals the sum, go to DONE one cycle after the last trailer byte; otherwise go to ERR.
- INSTR_LOADER_CHECKSUM_EN undefined:
  - The CSUM state and the accumulator are absent.
  - After the data, the loader goes straight to DONE.

## Structure
- Package instr_loader_pkg holds:
  - the state enum;
  - the header byte count constant (2);
  - the trailer byte count constant (4);
  - the byte-lane width constant (8).
- Sub-module word_assembler holds the byte-to-word shift logic, the lane counter, and the word_valid pulse. The FSM, address counter and checksum stay in instr_mem_loader.

## Test plan
- N=2, bytes 02 00 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0x0 and 0x00100093 @0x4; done=1, core_rst_n=1 two cycles after the last byte.
- Same image with s_valid toggled every other cycle -> identical writes; no extra or missing mem_we pulses.
- Header N=1025 (01 04) -> err=1, core_rst_n=0, no mem_we; a later start followed by a valid image -> done=1.
- rst pulled low in the middle of word 1 -> all outputs at their reset values immediately; a new start reloads from address 0.
- With INSTR_LOADER_CHECKSUM_EN:
  - correct trailer 0x001000A6 for the first image -> done=1;
  - trailer 0x001000A7 -> err=1 and core_rst_n stays 0.
- N=0, no checksum -> done=1 with no mem_we; start in DONE -> core_rst_n=0 and busy=1 in the next cycle.
